rs_latch_bank: RTL and testbench

RS_LATCH_BANK -- requirements
Module: rs_latch_bank

---
 rtl/dga_rs_pkg.sv | 17 +
 rtl/rs_input_filter.sv | 45 ++++
 rtl/rs_latch_bank.sv | 108 ++++++++++
 tb/tb_rs_latch_bank.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dga_rs_pkg.sv
// Shared constants for the gated R/S latch bank: S=R=1 resolution modes and parameter limits.
package dga_rs_pkg;

   localparam int RS_MODE_NEC     = 0;
   localparam int RS_MODE_SET_DOM = 1;
   localparam int RS_MODE_RST_DOM = 2;
   localparam int RS_MODE_TOGGLE  = 3;

   localparam int RS_WIDTH_MIN    = 1;
   localparam int RS_WIDTH_MAX    = 32;
   localparam int RS_FILT_CYC_MIN = 1;
   localparam int RS_FILT_CYC_MAX = 15;

   // Stability counter width; must hold RS_FILT_CYC_MAX.
   localparam int RS_CNT_W = 4;

endpackage

// File: rtl/rs_input_filter.sv
// One-channel stability filter: forwards the {g,s,r} triple only after FILT_CYC
// consecutive identical samples; any change restarts the count.
module rs_input_filter
   import dga_rs_pkg::*;
#(
   parameter int FILT_CYC = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] raw,
   output logic [2:0] fwd
);

   localparam logic [RS_CNT_W-1:0] FILT_LIM = RS_CNT_W'(FILT_CYC);

   logic [2:0]          prev;
   logic [RS_CNT_W-1:0] cnt;
   logic [RS_CNT_W-1:0] cnt_nxt;

   // cnt==0 means no history yet, so the first post-reset sample starts a fresh run.
   always_comb begin
      cnt_nxt = cnt;
      if ((cnt == '0) || (raw != prev)) begin
         cnt_nxt = RS_CNT_W'(1);
      end else if (cnt < FILT_LIM) begin
         cnt_nxt = cnt + RS_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev <= '0;
         cnt  <= '0;
         fwd  <= '0;
      end else begin
         prev <= raw;
         cnt  <= cnt_nxt;
         // Keeps forwarding while stable, so a held triple re-applies every cycle.
         if (cnt_nxt == FILT_LIM) begin
            fwd <= raw;
         end
      end
   end

endmodule

// File: rtl/rs_latch_bank.sv
// Bank of WIDTH independent gated R/S latches with sticky change flags and an irq.
// Optional input glitch filter enabled by macro RS_LATCH_BANK_GLITCH_FILTER_EN.
module rs_latch_bank
   import dga_rs_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MODE     = 0,
   parameter int FILT_CYC = 2
) (
   input  logic             sysclk,
   input  logic             sys_rst,
   input  logic [WIDTH-1:0] s_i,
   input  logic [WIDTH-1:0] r_i,
   input  logic [WIDTH-1:0] g_i,
   input  logic [WIDTH-1:0] clr_i,
   output logic [WIDTH-1:0] q_o,
   output logic [WIDTH-1:0] qb_o,
   output logic [WIDTH-1:0] chg_o,
   output logic             irq_o
);

   if ((WIDTH < RS_WIDTH_MIN) || (WIDTH > RS_WIDTH_MAX)) begin : g_bad_width
      $error("rs_latch_bank: WIDTH %0d out of range", WIDTH);
   end
   if ((FILT_CYC < RS_FILT_CYC_MIN) || (FILT_CYC > RS_FILT_CYC_MAX)) begin : g_bad_filt
      $error("rs_latch_bank: FILT_CYC %0d out of range", FILT_CYC);
   end
   if ((MODE < RS_MODE_NEC) || (MODE > RS_MODE_TOGGLE)) begin : g_bad_mode
      $error("rs_latch_bank: MODE %0d out of range", MODE);
   end

   logic [WIDTH-1:0] eff_s;
   logic [WIDTH-1:0] eff_r;
   logic [WIDTH-1:0] eff_g;

`ifdef RS_LATCH_BANK_GLITCH_FILTER_EN
   for (genvar i = 0; i < WIDTH; i++) begin : g_filt
      rs_input_filter #(
         .FILT_CYC(FILT_CYC)
      ) u_filt (
         .clk(sysclk),
         .rst(sys_rst),
         .raw({g_i[i], s_i[i], r_i[i]}),
         .fwd({eff_g[i], eff_s[i], eff_r[i]})
      );
   end
`else
   assign eff_s = s_i;
   assign eff_r = r_i;
   assign eff_g = g_i;
`endif

   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] qb_nxt;
   logic [WIDTH-1:0] chg_nxt;

   always_comb begin
      q_nxt  = q_o;
      qb_nxt = qb_o;
      for (int i = 0; i < WIDTH; i++) begin
         if (eff_g[i]) begin
            if (eff_s[i] && !eff_r[i]) begin
               q_nxt[i]  = 1'b1;
               qb_nxt[i] = 1'b0;
            end else if (!eff_s[i] && eff_r[i]) begin
               q_nxt[i]  = 1'b0;
               qb_nxt[i] = 1'b1;
            end else if (eff_s[i] && eff_r[i]) begin
               case (MODE)
                  RS_MODE_NEC: begin
                     q_nxt[i]  = 1'b1;
                     qb_nxt[i] = 1'b1;
                  end
                  RS_MODE_SET_DOM: begin
                     q_nxt[i]  = 1'b1;
                     qb_nxt[i] = 1'b0;
                  end
                  RS_MODE_RST_DOM: begin
                     q_nxt[i]  = 1'b0;
                     qb_nxt[i] = 1'b1;
                  end
                  default: begin
                     q_nxt[i]  = ~q_o[i];
                     qb_nxt[i] = ~qb_o[i];
                  end
               endcase
            end
         end
      end
      // A change on the same edge as a clear keeps the flag set.
      chg_nxt = (chg_o & ~clr_i) | (q_nxt ^ q_o) | (qb_nxt ^ qb_o);
   end

   always_ff @(posedge sysclk) begin
      if (sys_rst) begin
         q_o   <= '0;
         qb_o  <= '1;
         chg_o <= '0;
      end else begin
         q_o   <= q_nxt;
         qb_o  <= qb_nxt;
         chg_o <= chg_nxt;
      end
   end

   assign irq_o = |chg_o;

endmodule

// File: tb/tb_rs_latch_bank.sv
// Bench for rs_latch_bank: one instance per S=R=1 mode, scoreboard against a reference model.
module tb_rs_latch_bank;

   logic       sysclk;
   logic       sys_rst;
   logic [7:0] s_i;
   logic [7:0] r_i;
   logic [7:0] g_i;
   logic [7:0] clr_i;
   logic [7:0] q_w   [4];
   logic [7:0] qb_w  [4];
   logic [7:0] chg_w [4];
   logic       irq_w [4];

   int checks   = 0;
   int failures = 0;

   logic [95:0] exp_q[$];
   logic [7:0]  m_q   [4];
   logic [7:0]  m_qb  [4];
   logic [7:0]  m_chg [4];

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   for (genvar k = 0; k < 4; k++) begin : g_dut
      rs_latch_bank #(
         .WIDTH(8),
         .MODE(k),
         .FILT_CYC(2)
      ) u_dut (
         .sysclk(sysclk),
         .sys_rst(sys_rst),
         .s_i(s_i),
         .r_i(r_i),
         .g_i(g_i),
         .clr_i(clr_i),
         .q_o(q_w[k]),
         .qb_o(qb_w[k]),
         .chg_o(chg_w[k]),
         .irq_o(irq_w[k])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference behaviour of the latch bank without the filter.
   task automatic model_step(input logic rst_v, input logic [7:0] s_v, input logic [7:0] r_v,
                             input logic [7:0] g_v, input logic [7:0] clr_v);
      logic [7:0] nq;
      logic [7:0] nqb;
      for (int m = 0; m < 4; m++) begin
         if (rst_v) begin
            m_q[m]   = 8'h00;
            m_qb[m]  = 8'hFF;
            m_chg[m] = 8'h00;
         end else begin
            nq  = m_q[m];
            nqb = m_qb[m];
            for (int i = 0; i < 8; i++) begin
               if (g_v[i] && s_v[i] && !r_v[i]) begin
                  nq[i] = 1'b1; nqb[i] = 1'b0;
               end else if (g_v[i] && r_v[i] && !s_v[i]) begin
                  nq[i] = 1'b0; nqb[i] = 1'b1;
               end else if (g_v[i] && s_v[i] && r_v[i]) begin
                  if (m == 0)      begin nq[i] = 1'b1;      nqb[i] = 1'b1;       end
                  else if (m == 1) begin nq[i] = 1'b1;      nqb[i] = 1'b0;       end
                  else if (m == 2) begin nq[i] = 1'b0;      nqb[i] = 1'b1;       end
                  else             begin nq[i] = ~m_q[m][i]; nqb[i] = ~m_qb[m][i]; end
               end
            end
            m_chg[m] = (m_chg[m] & ~clr_v) | (nq ^ m_q[m]) | (nqb ^ m_qb[m]);
            m_q[m]   = nq;
            m_qb[m]  = nqb;
         end
      end
   endtask

   task automatic drive(input logic rst_v, input logic [7:0] s_v, input logic [7:0] r_v,
                        input logic [7:0] g_v, input logic [7:0] clr_v);
      sys_rst = rst_v;
      s_i     = s_v;
      r_i     = r_v;
      g_i     = g_v;
      clr_i   = clr_v;
   endtask

   task automatic pop_compare();
      logic [95:0] e;
      logic [23:0] sl;
      if (exp_q.size() == 0) begin
         check("sb_underflow", 32'd0, 32'd1);
         return;
      end
      e = exp_q.pop_front();
      for (int k = 0; k < 4; k++) begin
         sl = e[95-24*k -: 24];
         check($sformatf("sb_mode%0d_q_qb_chg", k), {8'h00, q_w[k], qb_w[k], chg_w[k]}, {8'h00, sl});
         check($sformatf("sb_mode%0d_irq", k), {31'd0, irq_w[k]}, {31'd0, |sl[7:0]});
      end
   endtask

   // Drive one cycle, push the model's prediction, then compare after the edge.
   task automatic step(input logic rst_v, input logic [7:0] s_v, input logic [7:0] r_v,
                       input logic [7:0] g_v, input logic [7:0] clr_v);
      drive(rst_v, s_v, r_v, g_v, clr_v);
      model_step(rst_v, s_v, r_v, g_v, clr_v);
      exp_q.push_back({m_q[0], m_qb[0], m_chg[0], m_q[1], m_qb[1], m_chg[1],
                       m_q[2], m_qb[2], m_chg[2], m_q[3], m_qb[3], m_chg[3]});
      @(posedge sysclk);
      #1;
      pop_compare();
   endtask

   task automatic tick(input logic rst_v, input logic [7:0] s_v, input logic [7:0] r_v,
                       input logic [7:0] g_v, input logic [7:0] clr_v);
      drive(rst_v, s_v, r_v, g_v, clr_v);
      @(posedge sysclk);
      #1;
   endtask

   initial begin
      drive(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
`ifdef RS_LATCH_BANK_GLITCH_FILTER_EN
      tick(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
      tick(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
      check("rst_q", {24'd0, q_w[0]}, 32'h00);
      check("rst_qb", {24'd0, qb_w[0]}, 32'hFF);
      check("rst_chg", {24'd0, chg_w[0]}, 32'h00);
      tick(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      tick(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      tick(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      // One-cycle set pulse must be swallowed.
      tick(1'b0, 8'h01, 8'h00, 8'h01, 8'h00);
      check("filt_short_c1", {24'd0, q_w[0]}, 32'h00);
      for (int c = 0; c < 4; c++) begin
         tick(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
         check("filt_short_hold", {24'd0, q_w[0]}, 32'h00);
      end
      check("filt_short_chg", {24'd0, chg_w[0]}, 32'h00);
      // Three-cycle pulse reaches q on the third edge.
      tick(1'b0, 8'h01, 8'h00, 8'h01, 8'h00);
      check("filt_long_c1", {24'd0, q_w[0]}, 32'h00);
      tick(1'b0, 8'h01, 8'h00, 8'h01, 8'h00);
      check("filt_long_c2", {24'd0, q_w[0]}, 32'h00);
      tick(1'b0, 8'h01, 8'h00, 8'h01, 8'h00);
      check("filt_long_c3_q", {24'd0, q_w[0]}, 32'h01);
      check("filt_long_c3_qb", {24'd0, qb_w[0]}, 32'hFE);
      check("filt_long_c3_chg", {24'd0, chg_w[0]}, 32'h01);
      check("filt_long_c3_irq", {31'd0, irq_w[0]}, 32'd1);
      tick(1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00);
      check("filt_rst_q", {24'd0, q_w[0]}, 32'h00);
`else
      step(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
      step(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
      step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      check("idle_q", {24'd0, q_w[0]}, 32'h00);
      check("idle_qb", {24'd0, qb_w[0]}, 32'hFF);
      check("idle_chg", {24'd0, chg_w[0]}, 32'h00);
      check("idle_irq", {31'd0, irq_w[0]}, 32'd0);

      step(1'b0, 8'h01, 8'h00, 8'h01, 8'h00);
      check("set0_q", {24'd0, q_w[0]}, 32'h01);
      check("set0_qb", {24'd0, qb_w[0]}, 32'hFE);
      check("set0_chg", {24'd0, chg_w[0]}, 32'h01);
      check("set0_irq", {31'd0, irq_w[0]}, 32'd1);
      step(1'b0, 8'h00, 8'h00, 8'h00, 8'h01);
      check("clr0_chg", {24'd0, chg_w[0]}, 32'h00);
      check("clr0_irq", {31'd0, irq_w[0]}, 32'd0);

      step(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
      step(1'b0, 8'h08, 8'h08, 8'h08, 8'h00);
      check("both_nec", {30'd0, q_w[0][3], qb_w[0][3]}, 32'b11);
      check("both_setdom", {30'd0, q_w[1][3], qb_w[1][3]}, 32'b10);
      check("both_rstdom", {30'd0, q_w[2][3], qb_w[2][3]}, 32'b01);
      check("both_tog1", {30'd0, q_w[3][3], qb_w[3][3]}, 32'b10);
      step(1'b0, 8'h08, 8'h08, 8'h08, 8'h00);
      check("both_tog2", {30'd0, q_w[3][3], qb_w[3][3]}, 32'b01);
      check("both_nec_hold", {30'd0, q_w[0][3], qb_w[0][3]}, 32'b11);
      step(1'b0, 8'h08, 8'h08, 8'h08, 8'h00);
      check("both_tog3", {30'd0, q_w[3][3], qb_w[3][3]}, 32'b10);
      step(1'b0, 8'h00, 8'h00, 8'h08, 8'h00);
      check("nec_idle_hold", {30'd0, q_w[0][3], qb_w[0][3]}, 32'b11);

      for (int c = 0; c < 5; c++) begin
         step(1'b0, 8'h04, 8'h00, 8'h00, 8'h00);
      end
      check("gate_off_q2", {31'd0, q_w[0][2]}, 32'd0);

      step(1'b0, 8'h00, 8'h00, 8'h00, 8'hFF);
      step(1'b0, 8'h20, 8'h00, 8'h20, 8'h20);
      check("clr_race_chg5", {31'd0, chg_w[0][5]}, 32'd1);
      step(1'b0, 8'h00, 8'h00, 8'h00, 8'h20);
      check("clr_after_chg5", {31'd0, chg_w[0][5]}, 32'd0);

      step(1'b1, 8'hFF, 8'h0F, 8'hFF, 8'hFF);
      check("rst_dom_q", {24'd0, q_w[3]}, 32'h00);
      check("rst_dom_qb", {24'd0, qb_w[3]}, 32'hFF);
      check("rst_dom_chg", {24'd0, chg_w[3]}, 32'h00);
      step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      check("post_rst_chg", {24'd0, chg_w[0]}, 32'h00);

      for (int c = 0; c < 200; c++) begin
         step(($urandom_range(0, 29) == 0),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)),
              ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00);
      end
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
